demux_1to2_8bit_stream: RTL and testbench

Registered 1-to-2 demultiplexer for 8-bit data streams. It is the receiving-side counterpart of the 2:1 data-select path. A single valid/ready input stream is steered by a per-beat select bit into one of two independent output channels. Each output channel buffers up to two bytes, so a stalled channel does not block traffic addressed to the other channel, and each channel keeps a wrapping count of accepted bytes. The block sits between a shared byte source and two downstream consumers.

---
 rtl/demux_1to2_8bit_stream.sv | 93 +++++++++
 tb/tb_demux_1to2_8bit_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to2_8bit_stream.sv
// Registered 1-to-2 stream demux: in_sel steers each accepted byte into
// one of two 2-entry FIFO channels, each with a wrapping byte counter.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   in_data/in_sel/in_valid input beat, destination select, beat present
//   in_ready                selected channel has room (combinational)
//   outN_data/outN_valid    head byte of channel N, channel non-empty
//   outN_ready              consumer of channel N takes the head byte
//   cntN                    bytes accepted into channel N, modulo 256
module demux_1to2_8bit_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);

    logic [WIDTH-1:0] mem [2][2];
    logic [1:0]       occ [2];
    logic [7:0]       cnt [2];
    logic [1:0]       rptr;
    logic [1:0]       wptr;
    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       oready;

    assign full[0] = (occ[0] == 2'd2);
    assign full[1] = (occ[1] == 2'd2);

    // Readiness only looks at the addressed channel, so a stalled
    // channel never blocks beats destined for the other one.
    assign in_ready = in_sel ? !full[1] : !full[0];

    assign push[0] = in_valid && in_ready && !in_sel;
    assign push[1] = in_valid && in_ready && in_sel;

    assign oready = {out1_ready, out0_ready};
    assign pop[0] = (occ[0] != 2'd0) && oready[0];
    assign pop[1] = (occ[1] != 2'd0) && oready[1];

    // Push and pop in the same cycle at occ=1 leaves occupancy unchanged;
    // the read pointer moves onto the slot just written, so the new byte
    // becomes the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                mem[c][0] <= '0;
                mem[c][1] <= '0;
                occ[c]    <= 2'd0;
                cnt[c]    <= 8'd0;
            end
            rptr <= 2'b00;
            wptr <= 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    mem[c][wptr[c]] <= in_data;
                    wptr[c]         <= !wptr[c];
                    cnt[c]          <= cnt[c] + 8'd1;
                end
                if (pop[c]) begin
                    rptr[c] <= !rptr[c];
                end
                case ({push[c], pop[c]})
                    2'b10:   occ[c] <= occ[c] + 2'd1;
                    2'b01:   occ[c] <= occ[c] - 2'd1;
                    default: occ[c] <= occ[c];
                endcase
            end
        end
    end

    assign out0_data  = mem[0][rptr[0]];
    assign out1_data  = mem[1][rptr[1]];
    assign out0_valid = (occ[0] != 2'd0);
    assign out1_valid = (occ[1] != 2'd0);
    assign cnt0       = cnt[0];
    assign cnt1       = cnt[1];

endmodule

// File: tb/tb_demux_1to2_8bit_stream.sv
// Bench for demux_1to2_8bit_stream: queue model checked every cycle
// plus directed scenarios with literal expectations.
module tb_demux_1to2_8bit_stream;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready = 1'b0;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready = 1'b0;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int errors = 0;
    int checks = 0;

    demux_1to2_8bit_stream #(.WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_sel(in_sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out0_data(out0_data),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out1_data(out1_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .cnt0(cnt0),
        .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: each channel is a queue of at most two bytes.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] mc0 = 8'd0;
    logic [7:0] mc1 = 8'd0;
    logic [7:0] log1[$];
    bit         m_rdy;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            mc0 = 8'd0;
            mc1 = 8'd0;
        end else begin
            if (out1_valid && out1_ready) log1.push_back(out1_data);
            m_rdy = in_sel ? (q1.size() < 2) : (q0.size() < 2);
            if (q0.size() > 0 && out0_ready) void'(q0.pop_front());
            if (q1.size() > 0 && out1_ready) void'(q1.pop_front());
            if (in_valid && m_rdy) begin
                if (in_sel) begin
                    q1.push_back(in_data);
                    mc1 = mc1 + 8'd1;
                end else begin
                    q0.push_back(in_data);
                    mc0 = mc0 + 8'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("out0_valid", {7'd0, out0_valid}, {7'd0, q0.size() != 0});
        chk("out1_valid", {7'd0, out1_valid}, {7'd0, q1.size() != 0});
        if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
        if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
        chk("cnt0", cnt0, mc0);
        chk("cnt1", cnt1, mc1);
        chk("in_ready", {7'd0, in_ready},
            {7'd0, in_sel ? (q1.size() < 2) : (q0.size() < 2)});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        int n;
        n = 0;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0h never accepted", d);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [7:0] c0_before;

    initial begin
        tick();
        tick();
        chk("rst_out0_valid", {7'd0, out0_valid}, 8'd0);
        chk("rst_cnt1", cnt1, 8'd0);
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        reset = 1'b0;
        tick();

        // Steering
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(8'hA5, 1'b0);
        chk("steer_out0", out0_data, 8'hA5);
        send(8'h3C, 1'b1);
        chk("steer_out1", out1_data, 8'h3C);
        chk("steer_out0_gone", {7'd0, out0_valid}, 8'd0);
        tick();
        chk("steer_cnt0", cnt0, 8'd1);
        chk("steer_cnt1", cnt1, 8'd1);

        // Backpressure isolation
        out0_ready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        in_data  = 8'h03;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("bp_refuse_03", {7'd0, in_ready}, 8'd0);
        in_data = 8'h04;
        in_sel  = 1'b1;
        #1;
        chk("bp_accept_04", {7'd0, in_ready}, 8'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_out1_04", out1_data, 8'h04);
        chk("bp_head_01", out0_data, 8'h01);
        out0_ready = 1'b1;
        tick();
        chk("bp_head_02", out0_data, 8'h02);
        tick();
        chk("bp_drained", {7'd0, out0_valid}, 8'd0);

        // Simultaneous push/pop at occ=1
        out0_ready = 1'b0;
        send(8'h10, 1'b0);
        c0_before = cnt0;
        out0_ready = 1'b1;
        in_data  = 8'h20;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        chk("pp_valid", {7'd0, out0_valid}, 8'd1);
        chk("pp_data", out0_data, 8'h20);
        chk("pp_cnt0", cnt0, c0_before + 8'd1);
        out0_ready = 1'b1;
        tick();
        chk("pp_occ1", {7'd0, out0_valid}, 8'd0);

        // Full-with-pop
        out1_ready = 1'b0;
        send(8'h55, 1'b1);
        send(8'h66, 1'b1);
        log1.delete();
        in_data    = 8'h77;
        in_sel     = 1'b1;
        in_valid   = 1'b1;
        out1_ready = 1'b1;
        #1;
        chk("fp_refuse", {7'd0, in_ready}, 8'd0);
        tick();
        chk("fp_ready", {7'd0, in_ready}, 8'd1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("fp_count", 8'(log1.size()), 8'd3);
        if (log1.size() == 3) begin
            chk("fp_order0", log1[0], 8'h55);
            chk("fp_order1", log1[1], 8'h66);
            chk("fp_order2", log1[2], 8'h77);
        end

        // Reset mid-cycle with channel 0 full
        out0_ready = 1'b0;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        chk("mr_full", {7'd0, in_ready}, 8'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_out0_valid", {7'd0, out0_valid}, 8'd0);
        chk("mr_out1_valid", {7'd0, out1_valid}, 8'd0);
        chk("mr_cnt0", cnt0, 8'd0);
        chk("mr_cnt1", cnt1, 8'd0);
        chk("mr_in_ready", {7'd0, in_ready}, 8'd1);
        tick();
        reset = 1'b0;
        send(8'h11, 1'b0);
        chk("mr_after_11", out0_data, 8'h11);
        out0_ready = 1'b1;
        tick();

        // Counter wrap on channel 1
        pulse_reset();
        out1_ready = 1'b1;
        in_sel     = 1'b1;
        in_valid   = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            in_data = 8'(i);
            tick();
            if (i == 255) chk("wrap_255", cnt1, 8'hFF);
            if (i == 256) chk("wrap_256", cnt1, 8'h00);
            if (i == 257) chk("wrap_257", cnt1, 8'h01);
            if (i % 64 == 0) chk("wrap_cnt0", cnt0, 8'h00);
        end
        in_valid = 1'b0;
        chk("wrap_cnt0_end", cnt0, 8'h00);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
